// File: rtl/descrambler_257.sv
// Additive X^58 + X^39 + 1 descrambler for 257-bit transcoded blocks, with valid/ready and an output register.
// Optional feature: define DESCR_BYPASS_EN to add a bypass input that passes blocks through while keeping the keystream aligned.
module descrambler_257 #(
    parameter int          W         = 257,
    parameter logic [57:0] SEED_INIT = 58'h3FFFFFFFFFFFFFF,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             seed_load,
    input  logic [57:0]      seed,
`ifdef DESCR_BYPASS_EN
    input  logic             bypass,
`endif
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] blk_cnt,
    output logic [57:0]      lfsr_state
);

    localparam int L = 58;

    // Returns {final LFSR state, descrambled block}; bit 0 of the block meets the keystream first.
    function automatic logic [L+W-1:0] descramble(input logic [W-1:0] blk, input logic [L-1:0] s0);
        logic [L-1:0] s;
        logic [W-1:0] o;
        logic         f;
        s = s0;
        o = '0;
        for (int i = 0; i < W; i++) begin
            f    = s[57] ^ s[38];
            o[i] = blk[i] ^ f;
            s    = {s[56:0], f};
        end
        return {s, o};
    endfunction

    logic [L-1:0] lfsr;
    logic [L-1:0] start_state;
    logic [L-1:0] next_state;
    logic [W-1:0] clear_data;
    logic [W-1:0] sel_data;
    logic         accept;

    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    // A seed_load in the accept cycle seeds this very block, not the next one.
    assign start_state = seed_load ? seed : lfsr;
    assign {next_state, clear_data} = descramble(in_data, start_state);

`ifdef DESCR_BYPASS_EN
    assign sel_data = bypass ? in_data : clear_data;
`else
    assign sel_data = clear_data;
`endif

    // LFSR advances only on accepted blocks, so backpressure cannot slip the keystream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= SEED_INIT;
        end else if (accept) begin
            lfsr <= next_state;
        end else if (seed_load) begin
            lfsr <= seed;
        end
    end

    // Output register stage: one-cycle latency, holds while downstream stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            blk_cnt   <= '0;
        end else if (accept) begin
            out_data  <= sel_data;
            out_valid <= 1'b1;
            blk_cnt   <= blk_cnt + CNT_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign lfsr_state = lfsr;

endmodule

// File: tb/tb_descrambler_257.sv
// Bench for descrambler_257: table of scrambled/clear block pairs through a scoreboard, plus reset, stall and seed sequences.
// Building with DESCR_BYPASS_EN adds the bypass sequence.
module tb_descrambler_257;

    localparam logic [57:0] SEED_INIT = 58'h3FFFFFFFFFFFFFF;
    localparam int NVEC = 1000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [256:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         seed_load = 1'b0;
    logic [57:0]  seed = '0;
    logic [256:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [31:0]  blk_cnt;
    logic [57:0]  lfsr_state;
`ifdef DESCR_BYPASS_EN
    logic         bypass = 1'b0;
`endif

    descrambler_257 dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .seed_load  (seed_load),
        .seed       (seed),
`ifdef DESCR_BYPASS_EN
        .bypass     (bypass),
`endif
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .blk_cnt    (blk_cnt),
        .lfsr_state (lfsr_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [256:0] din;
        logic [256:0] exp;
    } vec_t;

    vec_t         tab [NVEC];
    logic [256:0] sb [$];
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Keystream as a bit history k[n] = k[n-58] ^ k[n-39]; the initial state supplies the 58 oldest bits.
    function automatic logic [256:0] keystream(input logic [57:0] st, output logic [57:0] nx);
        logic         h [0:314];
        logic [256:0] k;
        for (int j = 0; j < 58; j++) h[j] = st[57-j];
        for (int n = 0; n < 257; n++) begin
            h[58+n] = h[n] ^ h[n+19];
            k[n]    = h[58+n];
        end
        for (int j = 0; j < 58; j++) nx[j] = h[314-j];
        return k;
    endfunction

    function automatic logic [256:0] rand_blk();
        logic [256:0] b;
        for (int j = 0; j < 9; j++) b[j*32 +: 32] = $urandom;
        b[256] = 1'($urandom);
        return b;
    endfunction

    // Scoreboard checker: whatever downstream takes must be the oldest expected block.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_underflow: got block %h, expected none", out_data);
            end else begin
                chk("sb_data", {63'd0, out_data}, {63'd0, sb.pop_front()});
            end
        end
    end

    task automatic send(input logic [256:0] d, input logic [256:0] e);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected accept");
        end
        in_valid = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        #1;
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [57:0]  ms;
        logic [256:0] held;
        logic [256:0] r;
        logic [256:0] p;
        logic [57:0]  lf;

        ms = SEED_INIT;
        for (int i = 0; i < NVEC; i++) begin
            tab[i].exp = rand_blk();
            tab[i].din = tab[i].exp ^ keystream(ms, ms);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {319'd0, out_valid}, 320'd0);
        chk("rst_lfsr", {262'd0, lfsr_state}, {262'd0, SEED_INIT});
        chk("rst_blk_cnt", {288'd0, blk_cnt}, 320'd0);
        chk("rst_out_data", {63'd0, out_data}, 320'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", {319'd0, in_ready}, 320'd1);

        // All-zero block from reset exposes the raw keystream: first 1 lands on bit 39.
        ms = SEED_INIT;
        @(posedge clk);
        #1;
        send('0, keystream(ms, ms));
        chk("zero_out_valid", {319'd0, out_valid}, 320'd1);
        chk("zero_low40", {280'd0, out_data[39:0]}, {280'd0, 40'h8000000000});
        chk("zero_blk_cnt", {288'd0, blk_cnt}, 320'd1);

        // Reset while a block is pending downstream.
        out_ready = 1'b0;
        #5;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", {319'd0, out_valid}, 320'd0);
        chk("midrst_lfsr", {262'd0, lfsr_state}, {262'd0, SEED_INIT});
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            if (i == 500) begin
                out_ready = 1'b0;
                held = out_data;
                lf   = lfsr_state;
                in_valid = 1'b1;
                in_data  = tab[i].din;
                #1;
                chk("bp_in_ready", {319'd0, in_ready}, 320'd0);
                for (int c = 0; c < 5; c++) begin
                    @(posedge clk);
                    #1;
                    chk("bp_in_ready", {319'd0, in_ready}, 320'd0);
                    chk("bp_out_data", {63'd0, out_data}, {63'd0, held});
                    chk("bp_lfsr", {262'd0, lfsr_state}, {262'd0, lf});
                end
                out_ready = 1'b1;
            end
            send(tab[i].din, tab[i].exp);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("loop_blk_cnt", {288'd0, blk_cnt}, 320'd1000);
        chk("loop_sb_empty", 320'(sb.size()), 320'd0);

        // Zero seed loaded with the accept: keystream is all zero and the LFSR stays zero.
        r = rand_blk();
        seed = '0;
        seed_load = 1'b1;
        send(r, r);
        seed_load = 1'b0;
        chk("seed0_lfsr", {262'd0, lfsr_state}, 320'd0);
        chk("seed0_blk_cnt", {288'd0, blk_cnt}, 320'd1001);
        chk("seed0_out_data", {63'd0, out_data}, {63'd0, r});

        // Seed load alone, with output stalled: only the LFSR may move.
        out_ready = 1'b0;
        seed = 58'h123456789ABCDEF;
        seed_load = 1'b1;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        chk("seedonly_lfsr", {262'd0, lfsr_state}, {262'd0, 58'h123456789ABCDEF});
        chk("seedonly_out_valid", {319'd0, out_valid}, 320'd1);
        chk("seedonly_out_data", {63'd0, out_data}, {63'd0, r});
        chk("seedonly_blk_cnt", {288'd0, blk_cnt}, 320'd1001);
        out_ready = 1'b1;

        ms = 58'h123456789ABCDEF;
        p = rand_blk();
        send(p ^ keystream(ms, ms), p);
        chk("seeded_lfsr", {262'd0, lfsr_state}, {262'd0, ms});

        ms = 58'h2A5A5A5C3C3C3C1;
        seed = ms;
        seed_load = 1'b1;
        p = rand_blk();
        send(p ^ keystream(ms, ms), p);
        seed_load = 1'b0;
        chk("seedacc_lfsr", {262'd0, lfsr_state}, {262'd0, ms});

`ifdef DESCR_BYPASS_EN
        reset_pulse();
        @(posedge clk);
        #1;
        ms = SEED_INIT;
        bypass = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r = rand_blk();
            p = keystream(ms, ms);
            send(r, r);
        end
        bypass = 1'b0;
        for (int i = 0; i < 3; i++) begin
            p = rand_blk();
            send(p ^ keystream(ms, ms), p);
        end
        chk("byp_lfsr", {262'd0, lfsr_state}, {262'd0, ms});
        chk("byp_blk_cnt", {288'd0, blk_cnt}, 320'd6);
`else
        reset_pulse();
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("final_sb_empty", 320'(sb.size()), 320'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
